// File: rtl/rv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rv_pipe_pkg
// Shared encodings for the 5-stage RV32I pipeline:
//   - ResultSrc mux encodings (ALU / MEM / PC+4)
//   - 4-bit ALUCtrl operation codes
//   - ctrlT, the packed per-instruction control bundle, and CTRL_NOP, the
//     all-zero bubble that the ID/EX register loads on a flush
// ---------------------------------------------------------------------------
package rv_pipe_pkg;

    // Result mux select
    localparam logic [1:0] RES_SRC_ALU = 2'b00;
    localparam logic [1:0] RES_SRC_MEM = 2'b01;
    localparam logic [1:0] RES_SRC_PC4 = 2'b10;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;

    // Control bundle carried from decode into execute
    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       aluSrc;
        logic       branch;
        logic       jump;
        logic [1:0] resultSrc;
        logic [3:0] aluCtrl;
    } ctrlT;

    // All-zero control never writes state, so it behaves as a NOP bubble
    localparam ctrlT CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage_if
// Decode-to-execute bundle for the ID/EX stage.
//   D-stage side : rs1D/rs2D/rdD, RD1D/RD2D/ImmExtD/PCD/PCPlus4D, decode
//                  control, and PCSrcE (branch/jump taken, resolved in EX)
//   E-stage side : registered copies (…E) of all of the above
//   Hazard side  : StallF, StallD, FlushD driven back upstream
// Modports:
//   master - the surrounding pipeline (drives D inputs, reads E and hazards)
//   slave  - the ID/EX stage itself
// ---------------------------------------------------------------------------
interface id_ex_hazard_stage_if #(
    parameter int XLEN = 32
);

    // Decode stage
    logic [4:0]      rs1D, rs2D, rdD;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic            RegWriteD, MemReadD, MemWriteD, ALUSrcD, BranchD, JumpD;
    logic [1:0]      ResultSrcD;
    logic [3:0]      ALUCtrlD;
    logic            PCSrcE;

    // Execute stage
    logic [4:0]      rs1E, rs2E, rdE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic            RegWriteE, MemReadE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [1:0]      ResultSrcE;
    logic [3:0]      ALUCtrlE;

    // Hazard controls
    logic            StallF, StallD, FlushD;

    modport master (
        output rs1D, rs2D, rdD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
               RegWriteD, MemReadD, MemWriteD, ALUSrcD, BranchD, JumpD,
               ResultSrcD, ALUCtrlD, PCSrcE,
        input  rs1E, rs2E, rdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               RegWriteE, MemReadE, MemWriteE, ALUSrcE, BranchE, JumpE,
               ResultSrcE, ALUCtrlE, StallF, StallD, FlushD
    );

    modport slave (
        input  rs1D, rs2D, rdD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
               RegWriteD, MemReadD, MemWriteD, ALUSrcD, BranchD, JumpD,
               ResultSrcD, ALUCtrlD, PCSrcE,
        output rs1E, rs2E, rdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
               RegWriteE, MemReadE, MemWriteE, ALUSrcE, BranchE, JumpE,
               ResultSrcE, ALUCtrlE, StallF, StallD, FlushD
    );

endinterface

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use detector.
//   memReadE, rdE : the instruction currently in EX
//   rs1D, rs2D    : source indices of the instruction in decode
//   lwStall       : decode needs a register the EX load has not produced yet
// rs2D is compared even for instructions that ignore rs2; the occasional
// false stall is cheaper than decoding operand usage here.
// ---------------------------------------------------------------------------
module load_use_detect (
    input  logic       memReadE,
    input  logic [4:0] rdE,
    input  logic [4:0] rs1D,
    input  logic [4:0] rs2D,
    output logic       lwStall
);

    // x0 is never a real dependency, so rdE == 0 cannot stall
    assign lwStall = memReadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage
// ID/EX pipeline register with load-use stall and control-hazard flush.
//   clk       : pipeline clock, rising edge
//   rst       : asynchronous, active-high reset
//   bus       : D-stage inputs, registered E-stage outputs and the
//               StallF/StallD/FlushD hazard controls (slave modport)
//   stall_cnt : saturating count of cycles that stalled IF/ID
//   flush_cnt : saturating count of cycles with a taken branch/jump
// The register has no enable: a stall holds IF/ID externally and loads a
// bubble here, so each load-use costs exactly one cycle.
// ---------------------------------------------------------------------------
module id_ex_hazard_stage
    import rv_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    id_ex_hazard_stage_if.slave  bus,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    ctrlT            ctrlD, ctrlE;
    logic [4:0]      rs1Q, rs2Q, rdQ;
    logic [XLEN-1:0] rd1Q, rd2Q, immQ, pcQ, pcPlus4Q;
    logic            lwStall, flushE, stallEvent;

    assign ctrlD = '{
        regWrite:  bus.RegWriteD,
        memRead:   bus.MemReadD,
        memWrite:  bus.MemWriteD,
        aluSrc:    bus.ALUSrcD,
        branch:    bus.BranchD,
        jump:      bus.JumpD,
        resultSrc: bus.ResultSrcD,
        aluCtrl:   bus.ALUCtrlD
    };

    load_use_detect uLoadUse (
        .memReadE (ctrlE.memRead),
        .rdE      (rdQ),
        .rs1D     (bus.rs1D),
        .rs2D     (bus.rs2D),
        .lwStall  (lwStall)
    );

    // A taken branch squashes the decode instruction, so stalling it is moot
    assign stallEvent = lwStall && !bus.PCSrcE;
    assign flushE     = lwStall || bus.PCSrcE;

    assign bus.StallF = stallEvent;
    assign bus.StallD = stallEvent;
    assign bus.FlushD = bus.PCSrcE;

    // Data fields are zeroed on a bubble too, which keeps waveforms readable
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every E register captures the pre-edge D values together
        if (rst) begin
            ctrlE    <= CTRL_NOP;
            rs1Q     <= '0;
            rs2Q     <= '0;
            rdQ      <= '0;
            rd1Q     <= '0;
            rd2Q     <= '0;
            immQ     <= '0;
            pcQ      <= '0;
            pcPlus4Q <= '0;
        end else if (flushE) begin
            ctrlE    <= CTRL_NOP;
            rs1Q     <= '0;
            rs2Q     <= '0;
            rdQ      <= '0;
            rd1Q     <= '0;
            rd2Q     <= '0;
            immQ     <= '0;
            pcQ      <= '0;
            pcPlus4Q <= '0;
        end else begin
            ctrlE    <= ctrlD;
            rs1Q     <= bus.rs1D;
            rs2Q     <= bus.rs2D;
            rdQ      <= bus.rdD;
            rd1Q     <= bus.RD1D;
            rd2Q     <= bus.RD2D;
            immQ     <= bus.ImmExtD;
            pcQ      <= bus.PCD;
            pcPlus4Q <= bus.PCPlus4D;
        end
    end

    // Perf counters stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallEvent && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (bus.PCSrcE && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.rs1E       = rs1Q;
    assign bus.rs2E       = rs2Q;
    assign bus.rdE        = rdQ;
    assign bus.RD1E       = rd1Q;
    assign bus.RD2E       = rd2Q;
    assign bus.ImmExtE    = immQ;
    assign bus.PCE        = pcQ;
    assign bus.PCPlus4E   = pcPlus4Q;
    assign bus.RegWriteE  = ctrlE.regWrite;
    assign bus.MemReadE   = ctrlE.memRead;
    assign bus.MemWriteE  = ctrlE.memWrite;
    assign bus.ALUSrcE    = ctrlE.aluSrc;
    assign bus.BranchE    = ctrlE.branch;
    assign bus.JumpE      = ctrlE.jump;
    assign bus.ResultSrcE = ctrlE.resultSrc;
    assign bus.ALUCtrlE   = ctrlE.aluCtrl;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_hazard_stage
// Directed-vector bench for id_ex_hazard_stage. Inputs change 1 ns after the
// rising edge; outputs are sampled a further 1 ns later, away from the edge.
// ---------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int numCompared   = 0;
    int numMismatched = 0;

    id_ex_hazard_stage_if #(.XLEN(XLEN)) bus ();

    id_ex_hazard_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearD();
        bus.rs1D = 0; bus.rs2D = 0; bus.rdD = 0;
        bus.RD1D = 0; bus.RD2D = 0; bus.ImmExtD = 0; bus.PCD = 0; bus.PCPlus4D = 0;
        bus.RegWriteD = 0; bus.MemReadD = 0; bus.MemWriteD = 0;
        bus.ALUSrcD = 0; bus.BranchD = 0; bus.JumpD = 0;
        bus.ResultSrcD = 0; bus.ALUCtrlD = 0;
        bus.PCSrcE = 0;
    endtask

    initial begin
        clearD();

        // Power-on reset
        #12;
        checkVal("rst_rdE",       32'(bus.rdE), 0);
        checkVal("rst_RegWriteE", 32'(bus.RegWriteE), 0);
        checkVal("rst_stall_cnt", 32'(stall_cnt), 0);
        checkVal("rst_StallF",    32'(bus.StallF), 0);
        rst = 1'b0;

        // Normal flow
        bus.rs1D = 5'd3; bus.rs2D = 5'd4; bus.rdD = 5'd7;
        bus.RegWriteD = 1; bus.ALUCtrlD = 4'h2;
        bus.RD1D = 32'h1111_0000; bus.PCD = 32'h0000_0100; bus.PCPlus4D = 32'h0000_0104;
        #1;
        checkVal("nf_StallF", 32'(bus.StallF), 0);
        checkVal("nf_FlushD", 32'(bus.FlushD), 0);
        tick();
        checkVal("nf_rs1E",      32'(bus.rs1E), 3);
        checkVal("nf_rs2E",      32'(bus.rs2E), 4);
        checkVal("nf_rdE",       32'(bus.rdE), 7);
        checkVal("nf_RegWriteE", 32'(bus.RegWriteE), 1);
        checkVal("nf_ALUCtrlE",  32'(bus.ALUCtrlE), 2);
        checkVal("nf_RD1E",      bus.RD1E, 32'h1111_0000);
        checkVal("nf_PCPlus4E",  bus.PCPlus4E, 32'h0000_0104);
        checkVal("nf_StallD",    32'(bus.StallD), 0);

        // Load-use: load x5, then consumer of x5
        clearD();
        bus.MemReadD = 1; bus.rdD = 5'd5; bus.rs1D = 5'd1; bus.rs2D = 5'd2;
        bus.RegWriteD = 1; bus.ResultSrcD = 2'b01;
        tick();
        checkVal("lu_MemReadE", 32'(bus.MemReadE), 1);
        clearD();
        bus.rs1D = 5'd5; bus.rs2D = 5'd6; bus.rdD = 5'd8; bus.RegWriteD = 1;
        #1;
        checkVal("lu_StallF", 32'(bus.StallF), 1);
        checkVal("lu_StallD", 32'(bus.StallD), 1);
        checkVal("lu_FlushD", 32'(bus.FlushD), 0);
        tick();
        checkVal("lu_bub_RegWriteE", 32'(bus.RegWriteE), 0);
        checkVal("lu_bub_rdE",       32'(bus.rdE), 0);
        checkVal("lu_bub_rs1E",      32'(bus.rs1E), 0);
        checkVal("lu_stall_cnt",     32'(stall_cnt), 1);
        checkVal("lu_StallF_clear",  32'(bus.StallF), 0);
        tick();
        checkVal("lu_held_rs1E", 32'(bus.rs1E), 5);
        checkVal("lu_held_rdE",  32'(bus.rdE), 8);
        checkVal("lu_stall_cnt_hold", 32'(stall_cnt), 1);

        // Back-to-back: load x9, dependent load x10 (on x9), consumer of x10 via rs2
        clearD();
        bus.MemReadD = 1; bus.rdD = 5'd9; bus.RegWriteD = 1;
        tick();
        bus.MemReadD = 1; bus.rs1D = 5'd9; bus.rdD = 5'd10; bus.RegWriteD = 1;
        #1;
        checkVal("bb_StallF_1", 32'(bus.StallF), 1);
        tick();
        checkVal("bb_bub_MemReadE", 32'(bus.MemReadE), 0);
        tick();
        checkVal("bb_load2_rdE", 32'(bus.rdE), 10);
        clearD();
        bus.rs1D = 5'd1; bus.rs2D = 5'd10; bus.rdD = 5'd12; bus.RegWriteD = 1;
        #1;
        checkVal("bb_StallF_2", 32'(bus.StallF), 1);
        tick();
        checkVal("bb_stall_cnt", 32'(stall_cnt), 3);
        checkVal("bb_StallF_clear", 32'(bus.StallF), 0);

        // x0 load never stalls
        clearD();
        bus.MemReadD = 1; bus.rdD = 5'd0;
        tick();
        clearD();
        #1;
        checkVal("x0_StallF", 32'(bus.StallF), 0);
        tick();
        checkVal("x0_stall_cnt", 32'(stall_cnt), 3);

        // Reset mid-stall: clears immediately, no pending stall afterwards
        clearD();
        bus.MemReadD = 1; bus.rdD = 5'd5; bus.RegWriteD = 1;
        tick();
        bus.MemReadD = 0; bus.rs1D = 5'd5; bus.rdD = 5'd5; bus.RegWriteD = 1;
        #1;
        checkVal("mr_StallF_pre", 32'(bus.StallF), 1);
        #1 rst = 1'b1;
        #1;
        checkVal("mr_rdE",       32'(bus.rdE), 0);
        checkVal("mr_RegWriteE", 32'(bus.RegWriteE), 0);
        checkVal("mr_MemReadE",  32'(bus.MemReadE), 0);
        checkVal("mr_stall_cnt", 32'(stall_cnt), 0);
        checkVal("mr_StallF",    32'(bus.StallF), 0);
        #1 rst = 1'b0;

        // Branch over stall
        clearD();
        bus.MemReadD = 1; bus.rdD = 5'd5; bus.RegWriteD = 1;
        tick();
        clearD();
        bus.rs1D = 5'd1; bus.rs2D = 5'd5; bus.rdD = 5'd11; bus.RegWriteD = 1;
        bus.PCSrcE = 1;
        #1;
        checkVal("br_StallF", 32'(bus.StallF), 0);
        checkVal("br_StallD", 32'(bus.StallD), 0);
        checkVal("br_FlushD", 32'(bus.FlushD), 1);
        tick();
        checkVal("br_rdE",       32'(bus.rdE), 0);
        checkVal("br_RegWriteE", 32'(bus.RegWriteE), 0);
        checkVal("br_rs2E",      32'(bus.rs2E), 0);
        checkVal("br_flush_cnt", 32'(flush_cnt), 1);
        checkVal("br_stall_cnt", 32'(stall_cnt), 0);

        // Saturation: 2^CNT_W + 3 more taken cycles
        repeat ((1 << CNT_W) + 3) tick();
        checkVal("sat_flush_cnt", 32'(flush_cnt), 32'h0000_FFFF);
        bus.PCSrcE = 0;
        tick();
        checkVal("sat_flush_cnt_hold", 32'(flush_cnt), 32'h0000_FFFF);
        checkVal("sat_stall_cnt",      32'(stall_cnt), 0);
        checkVal("post_rdE",           32'(bus.rdE), 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
